br_ckpt_stack: RTL and testbench
================================

# br_ckpt_stack

Branch checkpoint stack for the R10K pipeline. It sits beside `br_mask_ctrl` at dispatch and consumes the same branch-mask and resolution traffic. For each in-flight branch it holds one checkpoint slot per mask bit, storing the recovery state: ROB tail, free-list head and fall-back PC. On a mispredict it delivers the recovery state and a squash mask one cycle after resolution.

## Interface
Parameters:
- `BR_MASK_W`, 5: number of checkpoint slots; one per branch-mask bit.
- `ROB_IDX_W`, 5: ROB tail pointer width.
- `FL_PTR_W`, 6: free-list head pointer width.
- `PC_W`, 64: recovery PC width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `is_br_i`  in  1  [Dispatch] a branch dispatches this cycle.
- `br_mask_i`  in  BR_MASK_W  [br_mask_ctrl] current mask before this cycle's allocation.
- `rob_tail_i`  in  ROB_IDX_W  ROB tail pointer to checkpoint (the entry after the branch).
- `fl_head_i`  in  FL_PTR_W  free-list head to checkpoint.
- `recover_pc_i`  in  PC_W  the PC to refetch if this branch mispredicts.
- `br_state_i`  in  2  [ROB] 2'b00 none, `BR_PR_CORRECT`, or `BR_PR_WRONG`.
- `br_bit_i`  in  BR_MASK_W  one-hot bit of the resolving branch.
- `alloc_bit_o`  out  BR_MASK_W  one-hot slot given to the dispatching branch (combinational).
- `valid_o`  out  BR_MASK_W  occupied slots.
- `full_o`  out  1  all slots valid.
- `recover_o`  out  1  one-cycle recovery pulse.
- `recover_rob_tail_o`  out  ROB_IDX_W  restored ROB tail.
- `recover_fl_head_o`  out  FL_PTR_W  restored free-list head.
- `recover_pc_o`  out  PC_W  refetch PC.
- `squash_mask_o`  out  BR_MASK_W  bits to kill in the RS, ROB and LSQ.

## Operation
- **Slot contents.** Each slot i holds:
  - `valid[i]`
  - `rob_tail[i]`, `fl_head[i]`, `pc[i]`
  - `dep[i]`: mask of older branches this branch depends on.
- **Allocation.**
  - `alloc_bit_o` is the lowest-index zero bit of `br_mask_i | valid`.
  - It is all-zero when `full_o` is asserted.
- **Dispatch write.** When `is_br_i` is high, `full_o` is low and there is no `BR_PR_WRONG` this cycle, the allocated slot captures:
  - `rob_tail_i`, `fl_head_i`, `recover_pc_i`
  - `dep = br_mask_i & ~resolved_bit`, where `resolved_bit` is `br_bit_i` when `br_state_i == BR_PR_CORRECT`, else 0.
  - The slot's `valid` is set.
- **Correct resolution** (`BR_PR_CORRECT`):
  - clear `valid[k]`, where k is the bit set in `br_bit_i`;
  - clear bit k in every `dep[]`.
  - No recovery pulse.
- **Wrong resolution** (`BR_PR_WRONG`):
  - Next edge: `recover_o` = 1.
  - The recovery outputs take slot k's saved fields.
  - `squash_mask_o` = bit k OR every slot j with `valid[j]` and `dep[j][k]` set.
  - Every slot in `squash_mask_o`, including k, is invalidated.
- **Simultaneous events.**
  - Dispatch together with a wrong resolution: dispatch is dropped (the branch is younger and squashed).
  - Dispatch together with a correct resolution: both take effect.
  - A resolution whose `br_bit_i` is not valid, or is not one-hot: ignored, no state change.
- **Dispatch while full:** ignored; no slot is overwritten.
- **Reset:** all outputs are 0. This covers `valid_o`, `full_o`, `recover_o`, the recovery fields and `squash_mask_o`. All slots invalid, `dep` cleared. Reset mid-recovery drops the pending pulse.

## Timing
- `alloc_bit_o` is combinational, valid in the dispatch cycle. Slot contents and `valid_o` update at the next posedge.
- `full_o` is registered state: `&valid`.
- Recovery outputs are registered:
  - They are valid for exactly one cycle, starting at the posedge that samples `BR_PR_WRONG`.
  - `recover_o`, `squash_mask_o` and the recovery fields return to 0 the following cycle unless another wrong resolution occurs.
- Freed slots are reusable in the cycle after release.
- No back-pressure; at most one resolution and one dispatch per cycle.

## Test plan
- **Reset then five dispatches.**
  - Stimulus: after reset, dispatch with `is_br_i`=1 for 5 cycles; `br_mask_i` tracks `valid_o`; PCs 0x100..0x140.
  - Required: `alloc_bit_o` = 00001, 00010, 00100, 01000, 10000; `valid_o` = 11111 and `full_o` = 1 after the 5th edge.
  - Then: a 6th dispatch leaves the state unchanged.
- **Correct resolution frees a slot.**
  - Stimulus: from full, `BR_PR_CORRECT` with `br_bit_i`=00010.
  - Required: `valid_o` = 11101, `full_o` = 0, bit 1 cleared from every `dep`, `recover_o` stays 0.
- **Mispredict squashes younger branches.**
  - Stimulus: slots 0-3 valid with dep = 00000, 00001, 00011, 00111; `BR_PR_WRONG` with `br_bit_i`=00010.
  - Required, next cycle: `recover_o` = 1, `recover_pc_o` = slot 1 PC, `squash_mask_o` = 01110, `valid_o` = 00001.
  - Then: `recover_o` = 0 the cycle after.
- **Dispatch plus wrong resolution.**
  - Stimulus: `is_br_i`=1 in the same cycle as `BR_PR_WRONG` on bit 0.
  - Required: no new slot allocated; `valid_o` = 00000.
- **Dispatch plus correct resolution.**
  - Stimulus: slots 0-1 valid; correct on 00001 while dispatching with `br_mask_i` = 00011.
  - Required: new slot 2 written with dep = 00010; `valid_o` = 00110.
- **Reset during recovery.**
  - Stimulus: assert `rst` in the cycle `recover_o` would rise.
  - Required: all outputs 0, `valid_o` = 00000.

Source files
------------

// File: rtl/br_ckpt_stack.sv
// Branch checkpoint stack: one recovery slot per branch-mask bit. Each slot
// keeps the ROB tail, free-list head and fall-back PC of an in-flight branch,
// plus the mask of older branches it depends on. A mispredict delivers the
// saved state and a squash mask one cycle after resolution.
module br_ckpt_stack #(
   parameter int BR_MASK_W = 5,
   parameter int ROB_IDX_W = 5,
   parameter int FL_PTR_W  = 6,
   parameter int PC_W      = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 is_br_i,
   input  logic [BR_MASK_W-1:0] br_mask_i,
   input  logic [ROB_IDX_W-1:0] rob_tail_i,
   input  logic [FL_PTR_W-1:0]  fl_head_i,
   input  logic [PC_W-1:0]      recover_pc_i,
   input  logic [1:0]           br_state_i,
   input  logic [BR_MASK_W-1:0] br_bit_i,
   output logic [BR_MASK_W-1:0] alloc_bit_o,
   output logic [BR_MASK_W-1:0] valid_o,
   output logic                 full_o,
   output logic                 recover_o,
   output logic [ROB_IDX_W-1:0] recover_rob_tail_o,
   output logic [FL_PTR_W-1:0]  recover_fl_head_o,
   output logic [PC_W-1:0]      recover_pc_o,
   output logic [BR_MASK_W-1:0] squash_mask_o
);

   // Resolution encodings shared with the ROB; 2'b00 means no resolution.
   localparam logic [1:0] BR_PR_CORRECT = 2'b01;
   localparam logic [1:0] BR_PR_WRONG   = 2'b10;

   // Slot state
   logic [BR_MASK_W-1:0] valid, valid_nxt;
   logic [BR_MASK_W-1:0] dep     [BR_MASK_W];
   logic [BR_MASK_W-1:0] dep_nxt [BR_MASK_W];
   logic [ROB_IDX_W-1:0] rob_tail_q [BR_MASK_W];
   logic [FL_PTR_W-1:0]  fl_head_q  [BR_MASK_W];
   logic [PC_W-1:0]      pc_q       [BR_MASK_W];
   logic                 full_q;

   // Decoded control
   logic                 res_ok;
   logic                 res_correct;
   logic                 res_wrong;
   logic [BR_MASK_W-1:0] resolved_bit;
   logic [BR_MASK_W-1:0] occupied;
   logic                 alloc_found;
   logic                 do_write;
   logic [BR_MASK_W-1:0] squash;
   logic [ROB_IDX_W-1:0] sel_rob_tail;
   logic [FL_PTR_W-1:0]  sel_fl_head;
   logic [PC_W-1:0]      sel_pc;

   // A resolution only counts when it names exactly one occupied slot.
   assign res_ok       = $onehot(br_bit_i) && |(br_bit_i & valid);
   assign res_correct  = res_ok && (br_state_i == BR_PR_CORRECT);
   assign res_wrong    = res_ok && (br_state_i == BR_PR_WRONG);
   assign resolved_bit = res_correct ? br_bit_i : '0;
   assign occupied     = br_mask_i | valid;

   // Allocation: lowest free slot, suppressed when the stack is full.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      alloc_bit_o = '0;
      alloc_found = 1'b0;
      for (int i = 0; i < BR_MASK_W; i++) begin
         if (!occupied[i] && !alloc_found) begin
            alloc_bit_o[i] = 1'b1;
            alloc_found    = 1'b1;
         end
      end
      if (full_q) alloc_bit_o = '0;
   end

   // A younger branch dispatching alongside a mispredict is itself squashed.
   assign do_write = is_br_i && !full_q && alloc_found && !res_wrong;

   // Squash mask and recovery-field select for the mispredicted slot.
   always_comb begin
      squash       = '0;
      sel_rob_tail = '0;
      sel_fl_head  = '0;
      sel_pc       = '0;
      if (res_wrong) begin
         squash = br_bit_i;
         for (int j = 0; j < BR_MASK_W; j++) begin
            if (valid[j] && |(dep[j] & br_bit_i)) squash[j] = 1'b1;
            if (br_bit_i[j]) begin
               sel_rob_tail = rob_tail_q[j];
               sel_fl_head  = fl_head_q[j];
               sel_pc       = pc_q[j];
            end
         end
      end
   end

   // Next valid/dep: release on correct, squash on wrong, then fill the new slot.
   always_comb begin
      valid_nxt = valid;
      for (int j = 0; j < BR_MASK_W; j++) dep_nxt[j] = dep[j];
      if (res_correct) begin
         valid_nxt = valid_nxt & ~br_bit_i;
         for (int j = 0; j < BR_MASK_W; j++) dep_nxt[j] = dep[j] & ~br_bit_i;
      end
      if (res_wrong) valid_nxt = valid_nxt & ~squash;
      if (do_write) begin
         valid_nxt = valid_nxt | alloc_bit_o;
         for (int j = 0; j < BR_MASK_W; j++) begin
            if (alloc_bit_o[j]) dep_nxt[j] = br_mask_i & ~resolved_bit;
         end
      end
   end

   // Slot control state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         valid  <= '0;
         full_q <= 1'b0;
         for (int j = 0; j < BR_MASK_W; j++) dep[j] <= '0;
      end else begin
         valid  <= valid_nxt;
         full_q <= &valid_nxt;
         for (int j = 0; j < BR_MASK_W; j++) dep[j] <= dep_nxt[j];
      end
   end

   // Checkpoint payload capture at dispatch.
   always_ff @(posedge clk) begin
      // NOTE: payload storage is not reset; a slot is only read after its valid bit has been set by a write.
      for (int j = 0; j < BR_MASK_W; j++) begin
         if (do_write && alloc_bit_o[j]) begin
            rob_tail_q[j] <= rob_tail_i;
            fl_head_q[j]  <= fl_head_i;
            pc_q[j]       <= recover_pc_i;
         end
      end
   end

   // One-cycle registered recovery pulse with the saved state.
   always_ff @(posedge clk) begin
      if (rst || !res_wrong) begin
         recover_o          <= 1'b0;
         recover_rob_tail_o <= '0;
         recover_fl_head_o  <= '0;
         recover_pc_o       <= '0;
         squash_mask_o      <= '0;
      end else begin
         recover_o          <= 1'b1;
         recover_rob_tail_o <= sel_rob_tail;
         recover_fl_head_o  <= sel_fl_head;
         recover_pc_o       <= sel_pc;
         squash_mask_o      <= squash;
      end
   end

   assign valid_o = valid;
   assign full_o  = full_q;

endmodule

// File: tb/tb_br_ckpt_stack.sv
// Self-checking bench for br_ckpt_stack. Directed stimulus pushes expected
// recovery responses into a scoreboard; a negedge monitor pops and compares
// whenever recover_o is high. Slot state is checked directly.
module tb_br_ckpt_stack;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_CORRECT = 2'b01;
   localparam logic [1:0] ST_WRONG   = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_br_i;
   logic [4:0]  br_mask_i;
   logic [4:0]  rob_tail_i;
   logic [5:0]  fl_head_i;
   logic [63:0] recover_pc_i;
   logic [1:0]  br_state_i;
   logic [4:0]  br_bit_i;
   logic [4:0]  alloc_bit_o;
   logic [4:0]  valid_o;
   logic        full_o;
   logic        recover_o;
   logic [4:0]  recover_rob_tail_o;
   logic [5:0]  recover_fl_head_o;
   logic [63:0] recover_pc_o;
   logic [4:0]  squash_mask_o;

   typedef struct packed {
      logic [4:0]  rob;
      logic [5:0]  fl;
      logic [63:0] pc;
      logic [4:0]  sq;
   } rec_t;

   rec_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [4:0] exp_mask;
   logic [4:0] exp_bit;

   br_ckpt_stack dut (
      .clk(clk), .rst(rst), .is_br_i(is_br_i), .br_mask_i(br_mask_i),
      .rob_tail_i(rob_tail_i), .fl_head_i(fl_head_i), .recover_pc_i(recover_pc_i),
      .br_state_i(br_state_i), .br_bit_i(br_bit_i), .alloc_bit_o(alloc_bit_o),
      .valid_o(valid_o), .full_o(full_o), .recover_o(recover_o),
      .recover_rob_tail_o(recover_rob_tail_o), .recover_fl_head_o(recover_fl_head_o),
      .recover_pc_o(recover_pc_o), .squash_mask_o(squash_mask_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      is_br_i      = 1'b0;
      br_mask_i    = '0;
      rob_tail_i   = '0;
      fl_head_i    = '0;
      recover_pc_i = '0;
      br_state_i   = ST_NONE;
      br_bit_i     = '0;
   endtask

   task automatic set_dispatch(input logic [4:0] mask, input logic [4:0] rob,
                               input logic [5:0] fl, input logic [63:0] pc);
      is_br_i      = 1'b1;
      br_mask_i    = mask;
      rob_tail_i   = rob;
      fl_head_i    = fl;
      recover_pc_i = pc;
   endtask

   task automatic set_resolve(input logic [1:0] st, input logic [4:0] bits);
      br_state_i = st;
      br_bit_i   = bits;
   endtask

   task automatic expect_rec(input logic [4:0] rob, input logic [5:0] fl,
                             input logic [63:0] pc, input logic [4:0] sq);
      rec_t r;
      r.rob = rob; r.fl = fl; r.pc = pc; r.sq = sq;
      sb_q.push_back(r);
   endtask

   task automatic check_drained(input string name);
      check(name, 64'(sb_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: every recovery pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (recover_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_recover", 64'd1, 64'd0);
         end else begin
            rec_t r;
            r = sb_q.pop_front();
            check("rec_rob_tail", 64'(recover_rob_tail_o), 64'(r.rob));
            check("rec_fl_head",  64'(recover_fl_head_o),  64'(r.fl));
            check("rec_pc",       recover_pc_o,            r.pc);
            check("rec_squash",   64'(squash_mask_o),      64'(r.sq));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick();
      check("rst_valid",   64'(valid_o), 64'd0);
      check("rst_full",    64'(full_o), 64'd0);
      check("rst_recover", 64'(recover_o), 64'd0);
      check("rst_rob",     64'(recover_rob_tail_o), 64'd0);
      check("rst_fl",      64'(recover_fl_head_o), 64'd0);
      check("rst_pc",      recover_pc_o, 64'd0);
      check("rst_squash",  64'(squash_mask_o), 64'd0);
      rst = 1'b0;

      // Five dispatches fill the stack; dep of slot i becomes (1<<i)-1.
      exp_mask = '0;
      for (int i = 0; i < 5; i++) begin
         set_dispatch(exp_mask, 5'(i + 1), 6'(i * 3 + 10), 64'h100 + 64'(i * 16));
         exp_bit = 5'(1 << i);
         #1 check("alloc_fill", 64'(alloc_bit_o), 64'(exp_bit));
         tick();
         exp_mask = exp_mask | exp_bit;
      end
      idle();
      check("fill_valid", 64'(valid_o), 64'h1f);
      check("fill_full",  64'(full_o), 64'd1);

      // Dispatch while full is dropped.
      set_dispatch(5'b11111, 5'd31, 6'd63, 64'hdead);
      #1 check("alloc_full", 64'(alloc_bit_o), 64'd0);
      tick(); idle();
      check("full_valid_kept", 64'(valid_o), 64'h1f);
      check("full_still",      64'(full_o), 64'd1);

      // Correct resolution frees slot 1 and clears bit 1 from every dep.
      set_resolve(ST_CORRECT, 5'b00010);
      tick(); idle();
      check("corr_valid",   64'(valid_o), 64'b11101);
      check("corr_full",    64'(full_o), 64'd0);
      check("corr_norecov", 64'(recover_o), 64'd0);

      // Refill slot 1, then mispredict it: only slot 1 squashed if bit 1 left the deps.
      set_dispatch(5'b11101, 5'd7, 6'd20, 64'h200);
      #1 check("alloc_reuse", 64'(alloc_bit_o), 64'b00010);
      tick(); idle();
      check("reuse_valid", 64'(valid_o), 64'h1f);
      check("reuse_full",  64'(full_o), 64'd1);
      set_resolve(ST_WRONG, 5'b00010);
      expect_rec(5'd7, 6'd20, 64'h200, 5'b00010);
      tick(); idle();
      check("wrong1_valid", 64'(valid_o), 64'b11101);
      tick();
      check("wrong1_pulse_end", 64'(recover_o), 64'd0);
      check("wrong1_sq_end",    64'(squash_mask_o), 64'd0);
      check_drained("wrong1_seen");

      // Mispredict slot 0: original payload intact despite the dropped full dispatch.
      set_resolve(ST_WRONG, 5'b00001);
      expect_rec(5'd1, 6'd10, 64'h100, 5'b11101);
      tick(); idle();
      check("wrong0_valid", 64'(valid_o), 64'd0);
      check("wrong0_full",  64'(full_o), 64'd0);
      tick();
      check_drained("wrong0_seen");

      // Slots 0-3 with dep 0,1,3,7; mispredict slot 1 squashes 1..3.
      exp_mask = '0;
      for (int i = 0; i < 4; i++) begin
         set_dispatch(exp_mask, 5'(i + 10), 6'(i + 30), 64'h300 + 64'(i * 16));
         tick();
         exp_mask = exp_mask | 5'(1 << i);
      end
      idle();
      check("four_valid", 64'(valid_o), 64'b01111);
      set_resolve(ST_WRONG, 5'b00010);
      expect_rec(5'd11, 6'd31, 64'h310, 5'b01110);
      tick(); idle();
      check("sq_valid", 64'(valid_o), 64'b00001);
      tick();
      check("sq_pulse_end", 64'(recover_o), 64'd0);
      check_drained("sq_seen");

      // Dispatch together with a wrong resolution: dispatch dropped.
      set_dispatch(5'b00001, 5'd3, 6'd3, 64'hbad);
      set_resolve(ST_WRONG, 5'b00001);
      expect_rec(5'd10, 6'd30, 64'h300, 5'b00001);
      tick(); idle();
      check("dw_valid", 64'(valid_o), 64'd0);
      tick();
      check_drained("dw_seen");

      // Dispatch together with a correct resolution: both happen, dep = 00010.
      set_dispatch(5'b00000, 5'd1, 6'd1, 64'h500);
      tick();
      set_dispatch(5'b00001, 5'd2, 6'd2, 64'h510);
      tick();
      set_dispatch(5'b00011, 5'd3, 6'd3, 64'h520);
      set_resolve(ST_CORRECT, 5'b00001);
      #1 check("dc_alloc", 64'(alloc_bit_o), 64'b00100);
      tick(); idle();
      check("dc_valid", 64'(valid_o), 64'b00110);
      set_resolve(ST_WRONG, 5'b00010);
      expect_rec(5'd2, 6'd2, 64'h510, 5'b00110);
      tick(); idle();
      check("dc_sq_valid", 64'(valid_o), 64'd0);
      tick();
      check_drained("dc_seen");

      // Non-one-hot and unoccupied resolutions are ignored.
      set_dispatch(5'b00000, 5'd4, 6'd4, 64'h600);
      tick(); idle();
      set_resolve(ST_WRONG, 5'b00011);
      tick(); idle();
      check("ign_multi_valid", 64'(valid_o), 64'b00001);
      check("ign_multi_rec",   64'(recover_o), 64'd0);
      set_resolve(ST_WRONG, 5'b00100);
      tick(); idle();
      check("ign_free_valid", 64'(valid_o), 64'b00001);
      check("ign_free_rec",   64'(recover_o), 64'd0);
      set_resolve(ST_CORRECT, 5'b01000);
      tick(); idle();
      check("ign_corr_valid", 64'(valid_o), 64'b00001);

      // Reset in the cycle the recovery pulse would rise drops it.
      set_resolve(ST_WRONG, 5'b00001);
      rst = 1'b1;
      tick();
      check("rr_recover", 64'(recover_o), 64'd0);
      check("rr_rob",     64'(recover_rob_tail_o), 64'd0);
      check("rr_fl",      64'(recover_fl_head_o), 64'd0);
      check("rr_pc",      recover_pc_o, 64'd0);
      check("rr_squash",  64'(squash_mask_o), 64'd0);
      check("rr_valid",   64'(valid_o), 64'd0);
      check("rr_full",    64'(full_o), 64'd0);
      rst = 1'b0;
      idle();
      tick(); tick();
      check("rr_after_recover", 64'(recover_o), 64'd0);
      check_drained("final_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
